// File: rtl/uart_rx_deframer_if.sv
// Parallel side of the UART receive deframer: serial input, FIFO-full status,
// received byte and its one-cycle status strobes.
interface uart_rx_deframer_if;
    logic       rx_sync;
    logic       fifo_full;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        input  rx_sync,
        input  fifo_full,
        output data,
        output data_valid,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output rx_sync,
        output fifo_full,
        input  data,
        input  data_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receive deframer: counts clocks per bit, samples mid-bit and emits
// bytes plus single-cycle framing-error / overrun strobes for an RX FIFO.
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_rx_deframer_if.master   bus
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic [2:0]       state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [2:0]       idx_q,        idx_d;
    logic [7:0]       shift_q,      shift_d;
    logic [7:0]       data_q,       data_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q,  frame_err_d;
    logic             overrun_q,    overrun_d;

    logic half_done;
    logic bit_done;

    assign half_done = (cnt_q == HALF_LAST);
    assign bit_done  = (cnt_q == BIT_LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.rx_sync) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end

            // A start bit that is high again at its midpoint is a line glitch.
            S_START: begin
                if (half_done) begin
                    cnt_d = '0;
                    if (!bus.rx_sync) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DATA: begin
                if (bit_done) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = bus.rx_sync;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // fifo_full only matters here, at the stop-bit sample.
            S_STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bus.rx_sync) begin
                        state_d = S_IDLE;
                        if (bus.fifo_full) begin
                            overrun_d = 1'b1;
                        end else begin
                            data_d       = shift_q;
                            data_valid_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // Hold off while the line sits in break so it cannot look like a new start bit.
            S_WAIT_HIGH: begin
                if (bus.rx_sync) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state_q != S_IDLE);

    a_flags_exclusive: assert property (@(posedge clk) disable iff (rst)
        $onehot0({data_valid_q, frame_err_q, overrun_q}));

    a_valid_single: assert property (@(posedge clk) disable iff (rst)
        data_valid_q |=> !data_valid_q);

    a_ferr_single: assert property (@(posedge clk) disable iff (rst)
        frame_err_q |=> !frame_err_q);

    a_ovr_single: assert property (@(posedge clk) disable iff (rst)
        overrun_q |=> !overrun_q);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at 16 clocks per bit; expected strobes are
// queued at stimulus time and matched by an independent output monitor.
module tb_uart_rx_deframer;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    localparam int K_VALID = 1;
    localparam int K_FERR  = 2;
    localparam int K_OVR   = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_deframer_if bus_if ();

    uart_rx_deframer #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         edge_cnt = 0;
    exp_t       sb_q[$];
    logic [7:0] model_data = 8'h00;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    exp_t mon_e;
    int   mon_kind;
    always @(negedge clk) begin
        if (!rst && (bus_if.data_valid || bus_if.frame_err || bus_if.overrun)) begin
            case ({bus_if.data_valid, bus_if.frame_err, bus_if.overrun})
                3'b100:  mon_kind = K_VALID;
                3'b010:  mon_kind = K_FERR;
                3'b001:  mon_kind = K_OVR;
                default: mon_kind = 7;
            endcase
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got kind=%0d data=0x%0h at edge %0d, required no pulse",
                         mon_kind, bus_if.data, edge_cnt);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_kind", mon_kind, mon_e.kind);
                check("pulse_data", int'(bus_if.data), int'(mon_e.data));
                check("pulse_cycle", edge_cnt, mon_e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        bus_if.rx_sync = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one full 160-clock frame starting at a falling edge and queues its outcome.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic ff,
                              output int busy_cnt);
        exp_t       e;
        logic [9:0] bits;
        bits  = {stop_bit, b, 1'b0};
        e.cyc = edge_cnt + 1 + HALF + 9 * CPB;
        if (!stop_bit) begin
            e.kind = K_FERR;
            e.data = model_data;
        end else if (ff) begin
            e.kind = K_OVR;
            e.data = model_data;
        end else begin
            e.kind     = K_VALID;
            e.data     = b;
            model_data = b;
        end
        sb_q.push_back(e);
        $display("frame 0x%0h stop=%0b fifo_full=%0b -> expect kind %0d data 0x%0h at edge %0d",
                 b, stop_bit, ff, e.kind, e.data, e.cyc);
        bus_if.fifo_full = ff;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < CPB; j++) begin
                bus_if.rx_sync = bits[i];
                @(negedge clk);
                busy_cnt += int'(bus_if.busy);
            end
        end
        bus_if.fifo_full = 1'b0;
    endtask

    initial begin
        int         bc;
        logic [9:0] rbits;

        bus_if.rx_sync   = 1'b1;
        bus_if.fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",       int'(bus_if.data),       0);
        check("rst_data_valid", int'(bus_if.data_valid), 0);
        check("rst_frame_err",  int'(bus_if.frame_err),  0);
        check("rst_overrun",    int'(bus_if.overrun),    0);
        check("rst_busy",       int'(bus_if.busy),       0);
        rst = 1'b0;
        idle(5);

        send_frame(8'hA5, 1'b1, 1'b0, bc);
        check("busy_len_a5", bc, 152);
        idle(4);

        send_frame(8'h00, 1'b1, 1'b0, bc);
        check("busy_len_00", bc, 152);
        send_frame(8'hFF, 1'b1, 1'b0, bc);
        check("busy_len_ff", bc, 152);
        idle(4);

        // Four-clock low glitch: start check at E0+8 sees the line high again.
        bc = 0;
        for (int i = 0; i < 12; i++) begin
            bus_if.rx_sync = (i < 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            bc += int'(bus_if.busy);
        end
        $display("glitch: busy cycles=%0d", bc);
        check("glitch_busy_len", bc, 8);
        idle(4);

        send_frame(8'h3C, 1'b0, 1'b0, bc);
        repeat (40) @(negedge clk);
        check("wait_high_busy", int'(bus_if.busy), 1);
        check("wait_high_data", int'(bus_if.data), 8'hFF);
        bus_if.rx_sync = 1'b1;
        @(negedge clk);
        check("wait_high_exit", int'(bus_if.busy), 0);
        idle(4);

        send_frame(8'h5A, 1'b1, 1'b1, bc);
        idle(4);
        send_frame(8'h5A, 1'b1, 1'b0, bc);
        idle(4);

        // Abort a frame during data bit 4 with an asynchronous reset.
        rbits = {1'b1, 8'h81, 1'b0};
        for (int k = 0; k < CPB + 4 * CPB + 8; k++) begin
            bus_if.rx_sync = rbits[k / CPB];
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        $display("mid-frame reset: data=0x%0h busy=%0b", bus_if.data, bus_if.busy);
        check("arst_data",       int'(bus_if.data),       0);
        check("arst_data_valid", int'(bus_if.data_valid), 0);
        check("arst_frame_err",  int'(bus_if.frame_err),  0);
        check("arst_overrun",    int'(bus_if.overrun),    0);
        check("arst_busy",       int'(bus_if.busy),       0);
        @(negedge clk);
        bus_if.rx_sync = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        model_data = 8'h00;
        idle(10);
        check("post_rst_idle", int'(bus_if.busy), 0);
        send_frame(8'h81, 1'b1, 1'b0, bc);
        check("busy_len_81", bc, 152);
        idle(20);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

UART receive deframer that consumes the serial line after the dff-based two-stage synchroniser and produces parallel bytes for the RX FIFO write port. It recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) by counting system clocks per bit and sampling mid-bit. It reports framing errors and FIFO-full overruns as single-cycle flags.

## Interface
- CLKS_PER_BIT, default 434: system clocks per UART bit (50 MHz / 115200); legal range 4 to 65535.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rx_sync  input  1  synchronised serial line; idle high.
- fifo_full  input  1  RX FIFO full, sampled on the stop-bit edge.
- data  output  8  last successfully received byte; held until the next good byte.
- data_valid  output  1  one-cycle write strobe to the FIFO; data is valid in the same cycle.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- overrun  output  1  one-cycle pulse; good frame arrived while fifo_full=1, byte dropped.
- busy  output  1  high whenever state is not IDLE.

## Operation
- HALF = CLKS_PER_BIT/2 (integer floor). The bit counter width is clog2(CLKS_PER_BIT); the bit index is 3 bits.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: on an edge where rx_sync=0, go to START with cnt=0. Otherwise stay.
- START: cnt increments each edge. On the edge where cnt==HALF-1:
  - if rx_sync=0, go to DATA with cnt=0 and bit index 0;
  - if rx_sync=1, treat as a glitch and return to IDLE with no flags.
- DATA: cnt increments each edge. On the edge where cnt==CLKS_PER_BIT-1:
  - shift rx_sync into shift-register bit[index] (LSB first) and set cnt=0;
  - after index 7, go to STOP.
- STOP: on the edge where cnt==CLKS_PER_BIT-1, sample rx_sync:
  - 1 and fifo_full=0: load data from the shift register, pulse data_valid, go to IDLE;
  - 1 and fifo_full=1: pulse overrun, leave data unchanged, go to IDLE;
  - 0: pulse frame_err, leave data unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until an edge sees rx_sync=1, then go to IDLE. This stops a break condition from retriggering a frame.
- data_valid, frame_err and overrun are mutually exclusive and never high for more than one cycle.
- A fifo_full change during the frame has no effect. Only its value at the stop-sample edge matters.
- rx_sync changes between sample edges are ignored. There is no majority voting.

## Timing
- Reset values: state=IDLE, cnt=0, index=0, shift register=0, data=8'h00, data_valid=0, frame_err=0, overrun=0, busy=0.
- Reset asserted mid-frame aborts immediately with no flag pulse. After deassertion the block waits in IDLE for the next low.
- Let E0 be the edge in IDLE that sees rx_sync=0.
  - Start bit confirmed at E0+HALF.
  - Data bit i sampled at E0+HALF+CLKS_PER_BIT·(i+1).
  - Stop bit sampled at E0+HALF+9·CLKS_PER_BIT.
  - Flags are registered at that edge and high for exactly the following cycle.
  - The block is back in IDLE (or WAIT_HIGH) on the same edge.
- busy rises at E0 and falls at the stop-sample edge, or at the WAIT_HIGH exit edge.
- A new start bit is accepted on the first edge after return to IDLE. Back-to-back frames with no idle gap are received.
- Upstream synchroniser latency (2 clk) is outside this block and is not compensated.

## Test plan
- CLKS_PER_BIT=16, send byte 8'hA5 with a good stop bit, fifo_full=0 → data_valid pulses once at E0+152 with data=8'hA5; busy is high from E0 to E0+152.
- Two back-to-back frames 8'h00 then 8'hFF with no idle gap → two data_valid pulses 160 clocks apart; data=8'h00 then 8'hFF.
- Low glitch of 4 clocks on rx_sync in IDLE (CLKS_PER_BIT=16) → returns to IDLE at E0+8; no flags; busy high for 8 cycles.
- Frame 8'h3C with stop bit low, then line held low for 40 more clocks → frame_err pulses once; data keeps its previous value; block stays in WAIT_HIGH until rx_sync=1, with no new frame started.
- Good frame 8'h5A with fifo_full=1 at the stop sample → overrun pulses once, data_valid stays 0, data unchanged. Repeat with fifo_full=0 → data=8'h5A.
- Assert rst during data bit 4 of a frame → all outputs are 0 immediately (asynchronous); no flag pulse afterward. The next full frame 8'h81 is received correctly.
